// File: rtl/button_debouncer_pkg.sv
// Shared types and timing constants for the push-button debouncer and
// other board-input conditioning logic.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_e;

  localparam int unsigned CLK_HZ = 27_000_000;

  // 10 ms debounce window and 0.5 s long-press threshold at CLK_HZ.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 100;
  localparam int unsigned DEFAULT_LONG_CYCLES     = CLK_HZ / 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous board input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/button_debouncer.sv
// Debounces one raw push-button pin into a clean level, press/release/long
// pulses and a wrapping press counter; every output is registered.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned COUNT_W         = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_raw,
  output logic               pressed,
  output logic               press_pulse,
  output logic               release_pulse,
  output logic               long_pulse,
  output logic [COUNT_W-1:0] press_count
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned LONG_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYCLES);
  localparam logic              RELEASED_LVL = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic w_sync;
  logic r_s;

  deb_state_e         r_state, w_state_nxt;
  logic [DEB_W-1:0]   r_deb_cnt, w_deb_nxt;
  logic [LONG_W-1:0]  r_long_cnt, w_long_nxt;
  logic               r_pressed, w_pressed_nxt;
  logic               r_press_pulse, w_press_pulse_nxt;
  logic               r_release_pulse, w_release_pulse_nxt;
  logic               r_long_pulse, w_long_pulse_nxt;
  logic [COUNT_W-1:0] r_press_count, w_count_nxt;

  sync_2ff #(
    .RESET_VAL (RELEASED_LVL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (w_sync)
  );

  // Polarity-corrected, registered copy of the synchronised pin (1 = pressed).
  always_ff @(posedge clk) begin
    if (rst) r_s <= 1'b0;
    else     r_s <= w_sync ^ ACTIVE_LOW;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_deb_cnt       <= '0;
      r_long_cnt      <= '0;
      r_pressed       <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_long_pulse    <= 1'b0;
      r_press_count   <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_deb_cnt       <= w_deb_nxt;
      r_long_cnt      <= w_long_nxt;
      r_pressed       <= w_pressed_nxt;
      r_press_pulse   <= w_press_pulse_nxt;
      r_release_pulse <= w_release_pulse_nxt;
      r_long_pulse    <= w_long_pulse_nxt;
      r_press_count   <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_deb_nxt           = r_deb_cnt;
    w_long_nxt          = r_long_cnt;
    w_pressed_nxt       = r_pressed;
    w_press_pulse_nxt   = 1'b0;
    w_release_pulse_nxt = 1'b0;
    w_long_pulse_nxt    = 1'b0;
    w_count_nxt         = r_press_count;

    case (r_state)
      IDLE: begin
        if (r_s) begin
          w_state_nxt = PRESS_WAIT;
          w_deb_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!r_s) begin
          w_state_nxt = IDLE;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_nxt       = HELD;
          w_pressed_nxt     = 1'b1;
          w_press_pulse_nxt = 1'b1;
          w_count_nxt       = r_press_count + COUNT_W'(1);
          w_long_nxt        = '0;
        end else begin
          w_deb_nxt = r_deb_cnt + DEB_W'(1);
        end
      end
      HELD: begin
        if (!r_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_deb_nxt   = '0;
        end else if (r_long_cnt == LONG_LAST) begin
          // Parking at LONG_CYCLES keeps the long pulse to once per press.
          w_long_pulse_nxt = 1'b1;
          w_long_nxt       = LONG_SAT;
        end else if (r_long_cnt < LONG_LAST) begin
          w_long_nxt = r_long_cnt + LONG_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (r_s) begin
          w_state_nxt = HELD;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_nxt         = IDLE;
          w_pressed_nxt       = 1'b0;
          w_release_pulse_nxt = 1'b1;
        end else begin
          w_deb_nxt = r_deb_cnt + DEB_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign pressed       = r_pressed;
  assign press_pulse   = r_press_pulse;
  assign release_pulse = r_release_pulse;
  assign long_pulse    = r_long_pulse;
  assign press_count   = r_press_count;

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Input-side counterpart to the LED blinker. It reads one raw, bouncy, asynchronous push-button pin (Tang Nano buttons are active-low).
- It synchronises and debounces the pin, then produces a clean level, one-cycle press, release and long-press pulses, and a wrapping press counter.
- The counter is sized to drive the 6-LED bank directly.
- Sits between the board pin and application logic in the top level.

Parameters:
- DEBOUNCE_CYCLES, 270000, cycles the synchronised input must be stable before a press or release is accepted (10 ms at 27 MHz); must be >= 2.
- LONG_CYCLES, 13500000, cycles in HELD before long_pulse fires (0.5 s at 27 MHz); must be > DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.
- COUNT_W, 6, width of press_count.

Ports:
- clk  input  1  system clock (27 MHz)
- rst  input  1  synchronous, active-high reset
- btn_raw  input  1  raw asynchronous button pin
- pressed  output  1  debounced level, 1 while the button is held
- press_pulse  output  1  one-cycle pulse on an accepted press
- release_pulse  output  1  one-cycle pulse on an accepted release
- long_pulse  output  1  one-cycle pulse, at most once per press
- press_count  output  COUNT_W  accepted presses, wraps modulo 2^COUNT_W

Behaviour:
- Reset:
  - Synchronous and active-high; it overrides everything.
  - State = IDLE; all counters = 0; pressed, press_pulse, release_pulse, long_pulse = 0; press_count = 0.
  - Both sync flops load the released pin level (ACTIVE_LOW ? 1 : 0).
- Synchroniser:
  - Two flops; s = polarity-corrected sync output (1 = pressed).
  - Total sync delay is 2 edges.
- Counters and widths:
  - deb_cnt width = $clog2(DEBOUNCE_CYCLES).
  - long_cnt width = $clog2(LONG_CYCLES+1).
  - All registered outputs; no combinational path from btn_raw to any output.
- IDLE (pressed=0):
  - s=1 -> PRESS_WAIT, deb_cnt=0.
- PRESS_WAIT:
  - s=0 -> IDLE (bounce rejected, no pulse).
  - Else, if deb_cnt == DEBOUNCE_CYCLES-1 -> HELD; pressed<=1; press_pulse<=1; press_count<=press_count+1; long_cnt<=0.
  - Else deb_cnt++.
- HELD (pressed=1):
  - s=0 -> RELEASE_WAIT, deb_cnt=0.
  - Else, if long_cnt == LONG_CYCLES-1 -> long_pulse<=1 and long_cnt<=LONG_CYCLES, which saturates it so the pulse does not repeat.
  - Else, if long_cnt < LONG_CYCLES-1 -> long_cnt++.
- RELEASE_WAIT (pressed stays 1):
  - s=1 -> HELD; long_cnt keeps its value, so a long press already fired does not re-fire.
  - Else, if deb_cnt == DEBOUNCE_CYCLES-1 -> IDLE; pressed<=0; release_pulse<=1.
  - Else deb_cnt++.
  - long_cnt is frozen in this state.
- Latency:
  - Take the first clk edge that samples a stable new pin level as edge 0.
  - The press/release transition (pressed change plus pulse) is visible after edge DEBOUNCE_CYCLES+3.
- Pulse width:
  - Pulses are exactly 1 cycle.
  - press_pulse and release_pulse can never coincide.
  - long_pulse cannot coincide with press_pulse.
- Wrap-around:
  - press_count at 2^COUNT_W-1 plus one press -> 0, with no flag.
- Pin held pressed through reset:
  - After reset deasserts, it is treated as a new press.
  - press_pulse follows DEBOUNCE_CYCLES+3 edges later.
- Reset mid-operation:
  - Any state returns to IDLE next edge.
  - In-flight pulses are suppressed; press_count clears.

Decomposition:
- Shared package holds:
  - the state enum: IDLE=2'd0, PRESS_WAIT=2'd1, HELD=2'd2, RELEASE_WAIT=2'd3;
  - CLK_HZ = 27_000_000;
  - the default DEBOUNCE_CYCLES/LONG_CYCLES constants derived from CLK_HZ.
- One sub-module: sync_2ff (parameter RESET_VAL, ports clk, rst, d, q), reused for every other asynchronous board input.

Test Plan:
- All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=16, ACTIVE_LOW=1.
1. rst high 3 cycles with btn_raw=1 -> all outputs 0, press_count=0; hold 20 idle cycles after reset -> outputs unchanged.
2. btn_raw=0 from edge 0, held 40 cycles -> press_pulse high only after edge 7, pressed=1, press_count=1; long_pulse high only after edge 23; no second long_pulse.
3. Bounce: btn_raw=0 for 3 cycles then 1 -> no pulses, pressed stays 0, press_count=0. Also toggle every 2 cycles during release -> pressed stays 1, no release_pulse.
4. After case 2, btn_raw=1 from edge r -> release_pulse high only after edge r+7, pressed=0; long_pulse not re-fired on a re-press within RELEASE_WAIT.
5. 64 clean press/release cycles -> press_count 1..63 then 0; exactly 64 press_pulses and 64 release_pulses.
6. Assert rst while in HELD (long_cnt=10) -> next edge pressed=0, press_count=0, no long_pulse. With btn_raw still 0 after reset -> press_pulse 7 edges later, press_count=1.
